// File: rtl/ble_packet_link_engine_if.sv
// Handshake/bus bundle between the BLE packet link engine and its command/UART neighbours.
interface ble_packet_link_engine_if #(
    parameter int unsigned PKT_BYTES = 18,
    parameter int unsigned RSP_BYTES = 33
);
    logic                   abort;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [PKT_BYTES*8-1:0] cmd_data;
    logic [7:0]             cmd_len;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic [RSP_BYTES*8-1:0] rsp_data;
    logic [7:0]             rsp_len;
    logic                   rsp_valid;
    logic                   rsp_error;
    logic                   rsp_timeout;
    logic [3:0]             retries_used;
    logic                   busy;

    // master: the link engine; slave: command decoder / UART side
    modport master (
        input  abort, cmd_valid, cmd_data, cmd_len, tx_ready, rx_data, rx_valid,
        output cmd_ready, tx_data, tx_valid, rsp_data, rsp_len, rsp_valid, rsp_error,
               rsp_timeout, retries_used, busy
    );
    modport slave (
        output abort, cmd_valid, cmd_data, cmd_len, tx_ready, rx_data, rx_valid,
        input  cmd_ready, tx_data, tx_valid, rsp_data, rsp_len, rsp_valid, rsp_error,
               rsp_timeout, retries_used, busy
    );
endinterface

// File: rtl/ble_packet_link_engine.sv
// BLE packet link engine: sends one command packet MSB-byte-first, then captures the response.
// Define BLE_LINK_RETRY_EN to retransmit the packet on response timeout (up to MAX_RETRIES).
module ble_packet_link_engine #(
    parameter int unsigned PKT_BYTES   = 18,
    parameter int unsigned RSP_BYTES   = 33,
    parameter logic [15:0] TERM_WORD   = 16'hBEEF,
    parameter int unsigned TIMEOUT     = 4000000,
    parameter int unsigned MAX_RETRIES = 2
) (
    input logic                      clk,
    input logic                      reset,
    ble_packet_link_engine_if.master bus
);
    localparam int unsigned PKT_W       = PKT_BYTES * 8;
    localparam int unsigned RSP_W       = RSP_BYTES * 8;
    localparam logic [7:0]  PKT_LEN_MAX = 8'(PKT_BYTES);
    localparam logic [7:0]  RSP_LEN_MAX = 8'(RSP_BYTES);
    localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);
`ifdef BLE_LINK_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

    state_t           state_q, state_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       idx_q, idx_d;
    logic [31:0]      timer_q, timer_d, timer_inc;
    logic [7:0]       tx_data_d;
    logic             tx_valid_d;
    logic [RSP_W-1:0] rsp_data_d, rsp_shift;
    logic [7:0]       rsp_len_d, rsp_len_inc;
    logic [3:0]       retries_d;
    logic             rsp_valid_d, rsp_error_d, rsp_timeout_d;

    // Byte k of a packet, counted from the most significant end
    function automatic logic [7:0] pkt_byte(input logic [PKT_W-1:0] pkt, input logic [7:0] k);
        logic [PKT_W-1:0] shifted;
        shifted = pkt << {k, 3'b000};
        return shifted[PKT_W-1 -: 8];
    endfunction

    always_comb begin
        state_d       = state_q;
        pkt_d         = pkt_q;
        len_d         = len_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        tx_data_d     = bus.tx_data;
        tx_valid_d    = bus.tx_valid;
        rsp_data_d    = bus.rsp_data;
        rsp_len_d     = bus.rsp_len;
        retries_d     = bus.retries_used;
        rsp_valid_d   = 1'b0;
        rsp_error_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_shift     = {bus.rsp_data[RSP_W-9:0], bus.rx_data};
        rsp_len_inc   = bus.rsp_len + 8'd1;
        timer_inc     = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;

        if (bus.abort) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        pkt_d      = bus.cmd_data;
                        len_d      = (bus.cmd_len == 8'd0 || 32'(bus.cmd_len) > PKT_BYTES)
                                     ? PKT_LEN_MAX : bus.cmd_len;
                        idx_d      = 8'd0;
                        rsp_data_d = '0;
                        rsp_len_d  = 8'd0;
                        retries_d  = 4'd0;
                        tx_data_d  = pkt_byte(bus.cmd_data, 8'd0);
                        tx_valid_d = 1'b1;
                        state_d    = SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (idx_q == len_q - 8'd1) begin
                            tx_valid_d = 1'b0;
                            timer_d    = 32'd0;
                            state_d    = WAIT_RSP;
                        end else begin
                            idx_d     = idx_q + 8'd1;
                            tx_data_d = pkt_byte(pkt_q, idx_q + 8'd1);
                        end
                    end
                end
                WAIT_RSP: begin
                    // A byte arriving in the timeout cycle wins over the timeout
                    if (bus.rx_valid) begin
                        rsp_data_d = rsp_shift;
                        rsp_len_d  = rsp_len_inc;
                        timer_d    = 32'd0;
                        if (rsp_len_inc >= 8'd2 && rsp_shift[15:0] == TERM_WORD) begin
                            rsp_valid_d = 1'b1;
                            state_d     = IDLE;
                        end else if (rsp_len_inc == RSP_LEN_MAX) begin
                            rsp_error_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end else if (timer_inc >= TIMEOUT_CYC) begin
                        if (RETRY_EN && bus.retries_used < RETRY_LIMIT) begin
                            retries_d  = bus.retries_used + 4'd1;
                            rsp_data_d = '0;
                            rsp_len_d  = 8'd0;
                            idx_d      = 8'd0;
                            tx_data_d  = pkt_byte(pkt_q, 8'd0);
                            tx_valid_d = 1'b1;
                            state_d    = SEND;
                        end else begin
                            rsp_timeout_d = 1'b1;
                            state_d       = IDLE;
                        end
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            pkt_q            <= '0;
            len_q            <= 8'd0;
            idx_q            <= 8'd0;
            timer_q          <= 32'd0;
            bus.cmd_ready    <= 1'b1;
            bus.tx_data      <= 8'd0;
            bus.tx_valid     <= 1'b0;
            bus.rsp_data     <= '0;
            bus.rsp_len      <= 8'd0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_error    <= 1'b0;
            bus.rsp_timeout  <= 1'b0;
            bus.retries_used <= 4'd0;
            bus.busy         <= 1'b0;
        end else begin
            state_q          <= state_d;
            pkt_q            <= pkt_d;
            len_q            <= len_d;
            idx_q            <= idx_d;
            timer_q          <= timer_d;
            bus.cmd_ready    <= (state_d == IDLE);
            bus.tx_data      <= tx_data_d;
            bus.tx_valid     <= tx_valid_d;
            bus.rsp_data     <= rsp_data_d;
            bus.rsp_len      <= rsp_len_d;
            bus.rsp_valid    <= rsp_valid_d;
            bus.rsp_error    <= rsp_error_d;
            bus.rsp_timeout  <= rsp_timeout_d;
            bus.retries_used <= retries_d;
            bus.busy         <= (state_d != IDLE);
        end
    end
endmodule
